// File: rtl/wb_reg_responder.sv
// Wishbone-style register responder: 256x8 register file with configurable wait states,
// commit/read pulses and a wrapping transfer counter.
module wb_reg_responder #(
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic        tb_clk,
  input  logic        tb_rst,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [7:0]  dat_i,
  output logic [7:0]  dat_o,
  output logic        ack_o,
  output logic        wr_valid,
  output logic [7:0]  wr_adr,
  output logic [7:0]  wr_dat,
  output logic        rd_valid,
  output logic [7:0]  rd_adr,
  output logic [15:0] xfer_cnt
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("wb_reg_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t     state;
  logic       pend;
  logic       req_we;
  logic [7:0] req_adr;
  logic [7:0] req_dat;
  logic [3:0] wait_cnt;
  logic [7:0] mem [256];

  logic start;
  logic fire;
  logic sample;

  // The request sampled on one edge is acted on at the next; 'start' launches it,
  // 'fire' is the edge that commits it and raises ack_o.
  always_comb begin
    start  = pend && (state != WAIT);
    fire   = (start && !HAS_WAIT) || (state == WAIT && wait_cnt == 4'd0);
    sample = (state != WAIT) && !(start && HAS_WAIT);
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state    <= IDLE;
      pend     <= 1'b0;
      req_we   <= 1'b0;
      req_adr  <= 8'h00;
      req_dat  <= 8'h00;
      wait_cnt <= 4'd0;
      ack_o    <= 1'b0;
      wr_valid <= 1'b0;
      rd_valid <= 1'b0;
      dat_o    <= 8'h00;
      wr_adr   <= 8'h00;
      wr_dat   <= 8'h00;
      rd_adr   <= 8'h00;
      xfer_cnt <= 16'h0000;
    end else begin
      ack_o    <= fire;
      wr_valid <= fire && req_we;
      rd_valid <= fire && !req_we;

      // Latched request stays frozen from launch into WAIT until its ack.
      if (sample) begin
        pend <= stb_i;
        if (stb_i) begin
          req_we  <= we_i;
          req_adr <= adr_i;
          req_dat <= dat_i;
        end
      end else if (start) begin
        pend <= 1'b0;
      end

      if (fire) begin
        xfer_cnt <= xfer_cnt + 16'd1;
        if (req_we) begin
          wr_adr <= req_adr;
          wr_dat <= req_dat;
        end else begin
          dat_o  <= mem[req_adr];
          rd_adr <= req_adr;
        end
      end

      case (state)
        IDLE, ACK: begin
          if (start) begin
            if (HAS_WAIT) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ACK;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes commit on the ack edge, so a following read sees the new value.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (fire && req_we) begin
      mem[req_adr] <= req_dat;
    end
  end

endmodule

// File: doc/wb_reg_responder.md
WB_REG_RESPONDER -- requirements
Module: wb_reg_responder

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- WAIT_CYCLES, 0: extra wait states before ack_o, legal range 0..15.
- RST_VAL, 8'h00: value loaded into every register-file entry on reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- tb_clk, in, 1: clock; all logic on its rising edge.
- tb_rst, in, 1: reset, asynchronous, active-high; clock is tb_clk.
- stb_i, in, 1: strobe; a bus request is present.
- we_i, in, 1: 1 = write, 0 = read.
- adr_i, in, 8: register address.
- dat_i, in, 8: write data.
- dat_o, out, 8: read data; valid while ack_o=1 on a read.
- ack_o, out, 1: transfer acknowledge, one cycle per transfer.
- wr_valid, out, 1: one-cycle pulse on write commit.
- wr_adr, out, 8: address of the committed write.
- wr_dat, out, 8: data of the committed write.
- rd_valid, out, 1: one-cycle pulse on read completion.
- rd_adr, out, 8: address of the completed read.
- xfer_cnt, out, 16: count of completed transfers.

Function
REQ-003 The block SHALL contain a 256 x 8 register file addressed by the full adr_i.
REQ-004 The FSM SHALL have three states, IDLE, WAIT and ACK, with these transitions:
- IDLE -> ACK when stb_i=1 and WAIT_CYCLES=0.
- IDLE -> WAIT when stb_i=1 and WAIT_CYCLES>0.
- WAIT -> ACK when the wait counter reaches 0.
- ACK -> IDLE when stb_i=0.
- ACK -> ACK or WAIT when stb_i=1: a new request, using the same rule as from IDLE.
REQ-005 The request (we_i, adr_i, dat_i) SHALL be latched on the rising edge where the FSM samples stb_i=1, in IDLE or ACK.
REQ-006 Entering WAIT SHALL load the wait counter with WAIT_CYCLES-1, and the counter SHALL decrement once per cycle while in WAIT.
REQ-007 For a request sampled at edge N, ack_o SHALL be high for exactly the cycle following edge N+1+WAIT_CYCLES.
REQ-008 ack_o SHALL be a registered output, asserted only in state ACK.
REQ-009 For a read, dat_o SHALL equal the register-file entry at the latched address, registered at the edge entering ACK.
REQ-010 For a write, dat_o SHALL hold its previous value.
REQ-011 A write SHALL update the register file at the edge entering ACK.
REQ-012 A read latched at that same edge SHALL return the newly written value; no stale data is allowed.
REQ-013 With WAIT_CYCLES=0 and stb_i held high, the block SHALL acknowledge one transfer every cycle (bulk mode), with ack in cycle k belonging to the address sampled at edge k-1.
REQ-014 Changes on stb_i, adr_i, we_i or dat_i while in WAIT SHALL be ignored; a latched request always completes.
REQ-015 wr_valid, wr_adr and wr_dat SHALL be asserted and updated in the same cycle as ack_o for writes, otherwise wr_valid=0 and wr_adr/wr_dat hold their values.
REQ-016 rd_valid and rd_adr SHALL be asserted and updated in the same cycle as ack_o for reads, otherwise rd_valid=0 and rd_adr holds its value.
REQ-017 rd_valid and wr_valid SHALL never be high in the same cycle.
REQ-018 xfer_cnt SHALL increment by 1 on every cycle with ack_o=1.
REQ-019 xfer_cnt SHALL wrap from 16'hFFFF to 16'h0000 without saturating or flagging.
REQ-020 WAIT_CYCLES outside 0..15 SHALL be rejected at elaboration.

Reset
REQ-021 While tb_rst=1, the block SHALL be in this state:
- FSM in IDLE;
- ack_o, wr_valid, rd_valid = 0;
- dat_o, wr_adr, wr_dat, rd_adr = 8'h00;
- xfer_cnt = 16'h0000;
- wait counter = 0;
- every register-file entry = RST_VAL.
REQ-022 Reset asserted mid-transfer (in WAIT or ACK) SHALL abort the transfer: no ack_o, no register-file update after reset release, and no pulse on rd_valid or wr_valid.
REQ-023 After tb_rst deasserts, the first request SHALL be sampled no earlier than the first rising edge of tb_clk.

Verification
REQ-024 Write 8'hA5 to 8'h3C, then read 8'h3C (WAIT_CYCLES=0) -> write: wr_valid=1, wr_adr=3C, wr_dat=A5, ack_o=1 for one cycle; read: ack_o=1, dat_o=A5, rd_valid=1, rd_adr=3C.
REQ-025 After reset, read 8'h77 with RST_VAL=8'h00 -> dat_o=00, ack_o=1 exactly 2 edges after stb_i is driven.
REQ-026 Fill all 256 entries with addr XOR 8'h5A, then bulk-read 00..FF with stb_i held (WAIT_CYCLES=0) -> 256 consecutive ack_o cycles, each dat_o = previous-cycle address XOR 5A, xfer_cnt=512.
REQ-027 WAIT_CYCLES=3, read 8'h10 with stb_i pulsed for one cycle only -> ack_o high only in the cycle after edge N+4, rd_adr=10.
REQ-028 WAIT_CYCLES=3, assert tb_rst during WAIT of a write of 8'hFF to 8'h20 -> no ack_o, no wr_valid; a later read of 8'h20 returns RST_VAL.
REQ-029 65536 single-cycle transfers from reset -> xfer_cnt wraps to 16'h0000; one more transfer -> 16'h0001.
